// File: rtl/egress_arbiter_pkg.sv
// Shared definitions for the egress arbitration path: port count, tdest width,
// arbiter state encoding and the AXI-Stream beat type used by the filter path.
package egress_arbiter_pkg;

   localparam int NUM_INGRESS_PORTS = 4;
   localparam int TDEST_W           = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [15:0]        tdata;
      logic               tvalid;
      logic               tlast;
      logic [TDEST_W-1:0] tdest;
   } axis_beat_t;

endpackage

// File: rtl/egress_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so the port after 'last'
// sits at bit 0, priority-encode the lowest set bit, then un-rotate the index.
module rr_picker
   import egress_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = NUM_INGRESS_PORTS
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [TDEST_W-1:0]   last,
   output logic [TDEST_W-1:0]   pick,
   output logic                 any
);

   logic [NUM_PORTS-1:0] rot;
   int                   start;

   always_comb begin
      start = (int'(last) + 1) % NUM_PORTS;
      for (int k = 0; k < NUM_PORTS; k++) begin
         rot[k] = req[(start + k) % NUM_PORTS];
      end
      pick = '0;
      any  = |req;
      // Descending scan so the lowest rotated index wins.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pick = TDEST_W'((start + k) % NUM_PORTS);
         end
      end
   end

endmodule

// File: rtl/egress_arbiter.sv
// Packet-granular round-robin arbiter for one egress AXI-Stream port; holds the
// grant from the first beat to the tlast handshake and counts forwarded packets.
//
// state | meaning
// IDLE  | no grant held; outputs quiet, arbitrate among matching requests
// BUSY  | grant held; granted ingress is muxed straight to the egress port
module egress_arbiter
   import egress_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = NUM_INGRESS_PORTS,
   parameter int DATA_W    = 16,
   parameter int PORT_ID   = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        en,
   input  logic [NUM_PORTS*DATA_W-1:0] in_tdata,
   input  logic [NUM_PORTS-1:0]        in_tvalid,
   input  logic [NUM_PORTS-1:0]        in_tlast,
   input  logic [NUM_PORTS*2-1:0]      in_tdest,
   output logic [NUM_PORTS-1:0]        in_tready,
   output logic [DATA_W-1:0]           out_tdata,
   output logic                        out_tvalid,
   output logic                        out_tlast,
   output logic [1:0]                  out_tdest,
   input  logic                        out_tready,
   output logic [15:0]                 pkt_count,
   output logic                        busy
);

   arb_state_t           state_q, state_d;
   logic [TDEST_W-1:0]   grant_q, last_grant_q, pick;
   logic [NUM_PORTS-1:0] req;
   logic                 any;
   logic                 eop;
   logic [15:0]          pkt_count_q;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         req[i] = in_tvalid[i] & en[i] &
                  (in_tdest[i*TDEST_W +: TDEST_W] == TDEST_W'(PORT_ID));
      end
   end

   rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
      .req  (req),
      .last (last_grant_q),
      .pick (pick),
      .any  (any)
   );

   always_comb begin
      state_d    = state_q;
      in_tready  = '0;
      out_tdata  = '0;
      out_tvalid = 1'b0;
      out_tlast  = 1'b0;
      out_tdest  = '0;
      eop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (any) state_d = BUSY;
         end
         BUSY: begin
            out_tdata          = in_tdata[int'(grant_q)*DATA_W +: DATA_W];
            out_tvalid         = in_tvalid[grant_q];
            out_tlast          = in_tlast[grant_q];
            out_tdest          = grant_q;
            in_tready[grant_q] = out_tready;
            eop                = out_tvalid & out_tready & out_tlast;
            if (eop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= TDEST_W'(NUM_PORTS - 1);
         pkt_count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any) grant_q <= pick;
         if (eop) begin
            last_grant_q <= grant_q;
            if (pkt_count_q != 16'hFFFF) pkt_count_q <= pkt_count_q + 16'd1;
         end
      end
   end

   assign busy      = (state_q == BUSY);
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_egress_arbiter.sv
// Self-checking bench for egress_arbiter: per-cycle comparison against a
// packet-level round-robin model, plus directed scenarios with literal expectations.
module tb_egress_arbiter;

   localparam int N = 4;
   localparam int W = 16;
   localparam logic [1:0] P = 2'd2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   en = '1;
   logic [N*W-1:0] in_tdata = '0;
   logic [N-1:0]   in_tvalid = '0;
   logic [N-1:0]   in_tlast = '0;
   logic [N*2-1:0] in_tdest = '0;
   logic [N-1:0]   in_tready;
   logic [W-1:0]   out_tdata;
   logic           out_tvalid, out_tlast;
   logic [1:0]     out_tdest;
   logic           out_tready = 1'b1;
   logic [15:0]    pkt_count;
   logic           busy;

   egress_arbiter #(.NUM_PORTS(N), .DATA_W(W), .PORT_ID(2)) dut (
      .clk(clk), .reset(reset), .en(en), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
      .in_tlast(in_tlast), .in_tdest(in_tdest), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
      .out_tdest(out_tdest), .out_tready(out_tready), .pkt_count(pkt_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-port beat queues: {tdest, tlast, tdata}
   logic [18:0] q[N][$];
   logic [N-1:0] hs = '0;
   bit bubbles = 0;

   typedef struct { int cyc; int port; logic [15:0] data; logic last; } beat_t;
   beat_t log_q[$];

   // Model: packet-level state
   bit          m_busy = 0, n_busy = 0;
   int          m_grant = 0, n_grant = 0;
   int          m_last = N - 1, n_last = N - 1;
   logic [15:0] m_cnt = '0, n_cnt = '0;
   int          grant_cyc = -1;

   always @(posedge clk) cyc++;

   always @(negedge reset) begin
      m_busy = 0; m_grant = 0; m_last = N - 1; m_cnt = '0;
      n_busy = 0; n_grant = 0; n_last = N - 1; n_cnt = '0;
   end

   always @(posedge clk) begin
      if (reset) begin
         m_busy = n_busy; m_grant = n_grant; m_last = n_last; m_cnt = n_cnt;
      end
   end

   always @(negedge clk) begin : compare
      logic [15:0] e_data;
      logic        e_valid, e_last;
      logic [N-1:0] e_ready;
      logic [1:0]  e_dest;
      bit          found;
      hs = in_tvalid & in_tready;
      if (!reset) begin
         chk("rst_out_tvalid", {31'd0, out_tvalid}, 0);
         chk("rst_in_tready", {28'd0, in_tready}, 0);
         chk("rst_pkt_count", {16'd0, pkt_count}, 0);
         n_busy = 0; n_grant = 0; n_last = N - 1; n_cnt = '0;
      end else begin
         e_data = '0; e_valid = 0; e_last = 0; e_ready = '0; e_dest = '0;
         if (m_busy) begin
            e_data           = in_tdata[m_grant*W +: W];
            e_valid          = in_tvalid[m_grant];
            e_last           = in_tlast[m_grant];
            e_ready[m_grant] = out_tready;
            e_dest           = 2'(m_grant);
         end
         chk("out_tdata", {16'd0, out_tdata}, {16'd0, e_data});
         chk("out_tvalid", {31'd0, out_tvalid}, {31'd0, e_valid});
         chk("out_tlast", {31'd0, out_tlast}, {31'd0, e_last});
         chk("in_tready", {28'd0, in_tready}, {28'd0, e_ready});
         chk("out_tdest", {30'd0, out_tdest}, {30'd0, e_dest});
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("pkt_count", {16'd0, pkt_count}, {16'd0, m_cnt});
         if (out_tvalid && out_tready)
            log_q.push_back('{cyc, int'(out_tdest), out_tdata, out_tlast});
         n_busy = m_busy; n_grant = m_grant; n_last = m_last; n_cnt = m_cnt;
         found = 0;
         if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
               int p;
               p = (m_last + k) % N;
               if (!found && in_tvalid[p] && en[p] && in_tdest[p*2 +: 2] == P) begin
                  found = 1; n_busy = 1; n_grant = p; grant_cyc = cyc;
               end
            end
         end else if (e_valid && out_tready && e_last) begin
            n_busy = 0;
            n_last = m_grant;
            if (m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
         end
      end
   end

   always @(posedge clk) begin : driver
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
         if (q[i].size() > 0 && !(bubbles && $urandom_range(3) == 0)) begin
            in_tvalid[i] = 1'b1;
            {in_tdest[i*2 +: 2], in_tlast[i], in_tdata[i*W +: W]} = q[i][0];
         end else begin
            in_tvalid[i] = 1'b0;
            in_tlast[i]  = 1'b0;
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic push_pkt(int port, int len, logic [15:0] base, logic [1:0] dest, bit rnd_tail);
      for (int b = 0; b < len; b++) begin
         logic [1:0] d;
         d = (b > 0 && rnd_tail) ? 2'($urandom_range(3)) : dest;
         q[port].push_back({d, (b == len - 1), base + 16'(b)});
      end
   endtask

   function automatic bit qs_empty();
      for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
      return 1;
   endfunction

   task automatic wait_done(string name, int max);
      int k = 0;
      while (k < max && !(qs_empty() && busy === 1'b0)) begin step(); k++; end
      chk(name, {31'd0, (k < max)}, 1);
   endtask

   task automatic wait_log(string name, int n, int max);
      int k = 0;
      while (k < max && log_q.size() < n) begin step(); k++; end
      chk(name, {31'd0, (k < max)}, 1);
   endtask

   task automatic clear_ports();
      for (int i = 0; i < N; i++) q[i].delete();
   endtask

   initial begin
      int first_idx[$];
      // Reset / idle
      reset = 1'b0;
      step(3);
      reset = 1'b1;
      step(3);
      chk("idle_out_tvalid", {31'd0, out_tvalid}, 0);
      chk("idle_out_tdata", {16'd0, out_tdata}, 0);
      chk("idle_out_tdest", {30'd0, out_tdest}, 0);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_pkt_count", {16'd0, pkt_count}, 0);

      // Single 3-beat packet from port 2
      log_q.delete();
      push_pkt(2, 3, 16'h00A1, P, 0);
      wait_done("single_done", 50);
      chk("single_nbeats", log_q.size(), 3);
      if (log_q.size() == 3) begin
         for (int b = 0; b < 3; b++) begin
            chk("single_data", {16'd0, log_q[b].data}, 32'h00A1 + b);
            chk("single_last", {31'd0, log_q[b].last}, (b == 2) ? 1 : 0);
            chk("single_dest", log_q[b].port, 2);
         end
         chk("single_latency", log_q[0].cyc - grant_cyc, 1);
      end
      chk("single_pkt_count", {16'd0, pkt_count}, 1);

      // Round-robin from a fresh reset: all ports offer 2-beat packets
      reset = 1'b0; step(2); reset = 1'b1; step();
      log_q.delete();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) push_pkt(i, 2, 16'((i << 8) | (r << 4)), P, 0);
      wait_done("rr_done", 200);
      for (int b = 0; b < log_q.size(); b++)
         if (b == 0 || log_q[b-1].last) first_idx.push_back(b);
      chk("rr_npkts", first_idx.size(), 12);
      if (first_idx.size() >= 5) begin
         for (int k = 0; k < 5; k++) chk("rr_order", log_q[first_idx[k]].port, k % N);
         for (int k = 1; k < 5; k++)
            chk("rr_gap", log_q[first_idx[k]].cyc - log_q[first_idx[k]-1].cyc, 2);
      end

      // Filtering: wrong tdest on port 1, disabled port 3
      log_q.delete();
      en = 4'b0111;
      push_pkt(1, 2, 16'h0B00, P ^ 2'd1, 0);
      push_pkt(3, 2, 16'h0C00, P, 0);
      step(10);
      chk("filt_no_output", log_q.size(), 0);
      chk("filt_tready1", {31'd0, in_tready[1]}, 0);
      chk("filt_busy", {31'd0, busy}, 0);
      clear_ports();
      step(2);
      en = '1;

      // Backpressure 1,0,0,1 with en[0] dropped after first beat
      log_q.delete();
      push_pkt(0, 4, 16'h0E00, P, 0);
      begin
         int k = 0;
         while (k < 20 && busy !== 1'b1) begin step(); k++; end
         chk("bp_grant", {31'd0, busy}, 1);
      end
      step(); out_tready = 1'b0; en[0] = 1'b0;
      step();
      step(); out_tready = 1'b1;
      wait_done("bp_done", 50);
      chk("bp_nbeats", log_q.size(), 4);
      if (log_q.size() == 4)
         for (int b = 0; b < 4; b++) begin
            chk("bp_data", {16'd0, log_q[b].data}, 32'h0E00 + b);
            chk("bp_last", {31'd0, log_q[b].last}, (b == 3) ? 1 : 0);
         end
      push_pkt(0, 2, 16'h0F00, P, 0);
      step(6);
      chk("bp_masked", log_q.size(), 4);
      clear_ports();
      step(2);
      en = '1;

      // Saturation
      force dut.pkt_count_q = 16'hFFFE;
      m_cnt = 16'hFFFE;
      #1 release dut.pkt_count_q;
      step();
      push_pkt(1, 1, 16'h0101, P, 0);
      push_pkt(2, 1, 16'h0202, P, 0);
      push_pkt(3, 1, 16'h0303, P, 0);
      wait_done("sat_done", 50);
      chk("sat_pkt_count", {16'd0, pkt_count}, 32'hFFFF);

      // Reset mid-packet: make last grant port 0, then abandon a port-1 packet
      push_pkt(0, 2, 16'h0D00, P, 0);
      wait_done("rm_pre", 50);
      log_q.delete();
      push_pkt(1, 4, 16'h0C10, P, 0);
      wait_log("rm_two_beats", 2, 50);
      push_pkt(0, 2, 16'h0D10, P, 0);
      #1 reset = 1'b0;
      #1;
      chk("rm_out_tvalid", {31'd0, out_tvalid}, 0);
      chk("rm_out_tdata", {16'd0, out_tdata}, 0);
      chk("rm_in_tready", {28'd0, in_tready}, 0);
      chk("rm_busy", {31'd0, busy}, 0);
      chk("rm_pkt_count", {16'd0, pkt_count}, 0);
      step(2);
      reset = 1'b1;
      log_q.delete();
      wait_log("rm_regrant", 1, 50);
      if (log_q.size() > 0) chk("rm_first_port", log_q[0].port, 0);
      wait_done("rm_done", 100);

      // Randomized traffic
      bubbles = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (q[i].size() == 0 && $urandom_range(3) == 0)
               push_pkt(i, $urandom_range(1, 4), 16'($urandom),
                        ($urandom_range(3) != 0) ? P : 2'($urandom_range(3)), 1);
            if ($urandom_range(15) == 0) en[i] = ~en[i];
         end
         out_tready = ($urandom_range(3) != 0);
         step();
      end
      bubbles = 0;
      en = '1;
      out_tready = 1'b1;
      step(200);
      chk("rand_drained", {31'd0, busy}, 0);
      clear_ports();
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/egress_arbiter.md
# egress_arbiter

Packet-granular round-robin arbiter for one egress AXI-Stream port of the packet filter. It collects the outputs of all ingress filters, selects those whose `tdest` addresses this egress port, and grants one whole packet at a time. It holds the grant until the `tlast` beat completes, then rotates priority. One instance sits behind the ingress filter array for each egress port, and it exports a per-port packet counter for the register interface.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of ingress requesters (equals `NUM_INGRESS_PORTS`).
- `DATA_W`, 16: tdata width.
- `PORT_ID`, 0: index of the egress port this instance serves; compared against `tdest`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  NUM_PORTS  per-ingress enable from the register block; gates new grants only.
- `in_tdata`  in  NUM_PORTS*DATA_W  flattened ingress data; port i occupies `[i*DATA_W +: DATA_W]`.
- `in_tvalid`  in  NUM_PORTS  ingress valid.
- `in_tlast`  in  NUM_PORTS  ingress last beat.
- `in_tdest`  in  NUM_PORTS*2  flattened destination egress index.
- `in_tready`  out  NUM_PORTS  ingress ready; at most one bit set.
- `out_tdata`  out  DATA_W  egress data.
- `out_tvalid`  out  1  egress valid.
- `out_tlast`  out  1  egress last.
- `out_tdest`  out  2  index of the ingress port currently granted.
- `out_tready`  in  1  egress ready.
- `pkt_count`  out  16  saturating count of packets forwarded.
- `busy`  out  1  high while a packet grant is held.

## Operation
- **Request:** `req[i] = in_tvalid[i] & en[i] & (in_tdest[i] == PORT_ID)`.
- **State machine:** two states, IDLE and BUSY. Registers: `grant` (2b), `last_grant` (2b).
- **IDLE:**
  - All `in_tready` = 0; `out_tvalid` = 0.
  - If any `req` is set, load `grant` with the first set `req` searching from `last_grant+1`, mod NUM_PORTS, with wrap-around.
  - Go to BUSY on the next edge.
- **BUSY:** combinational mux from the granted port.
  - `out_tdata/tlast/tvalid` = `in_*[grant]`.
  - `in_tready[grant]` = `out_tready`; all other `in_tready` = 0.
  - `out_tdest` = `grant`.
- **End of packet:** a handshake (`out_tvalid & out_tready & out_tlast`) in BUSY does the following on that edge:
  - `last_grant <= grant`.
  - `pkt_count <= pkt_count + 1`, saturating at 16'hFFFF with no wrap.
  - Return to IDLE.
- **Destination is sampled once:** `tdest` is checked only at grant time. During BUSY, `tdest` changes on the granted port are ignored.
- **Enable drop mid-packet:** deasserting `en[grant]` during BUSY does not abort the packet. It completes, and the mask applies from the next arbitration.
- **Valid bubbles:** `in_tvalid[grant]` dropping mid-packet holds BUSY; the grant stays held indefinitely.
- **Single requester:** it is re-granted after its own packet, with one IDLE cycle in between.
- **No requests:** IDLE holds; `last_grant` is unchanged.
- **Reset asserted:** asynchronously forces the following, regardless of any packet in flight (the partial packet is abandoned):
  - State IDLE.
  - `grant` = 0.
  - `last_grant` = NUM_PORTS-1, so port 0 has first priority.
  - `pkt_count` = 0.

## Timing
- **Reset values:**
  - `out_tvalid`, `out_tlast`, `busy`, and all `in_tready` = 0.
  - `out_tdata` = 0 (IDLE drives zero).
  - `out_tdest` = 0.
  - `pkt_count` = 0.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at edge N gives BUSY with the first beat presentable in cycle N+1.
- **Throughput:** within a packet, data passes with zero latency and no bubbles (1 beat/cycle while both sides are ready).
- **Inter-packet gap:** exactly 1 IDLE cycle between packets.
- **Counter timing:** `pkt_count` updates on the same edge as the tlast handshake.
- **busy:** registered; equals (state == BUSY).

## Structure
- **Shared package:** `NUM_INGRESS_PORTS`, `TDEST_W` = 2, the state enum `arb_state_t` {IDLE, BUSY}, and the AXIS struct typedefs used by the filter path.
- **Sub-module `rr_picker`:** combinational. Input `req[NUM_PORTS]` and `last[1:0]`; outputs `pick[1:0]` and `any`. It implements a rotate, priority-encode, un-rotate.
- **Top-level integration:** one `egress_arbiter` is instantiated per egress port, with `PORT_ID` = 0..3.

## Test plan
- **Reset/idle:** reset low, then released with no traffic. Expect all outputs 0, `busy` = 0, `pkt_count` = 0.
- **Single packet:** port 2 sends a 3-beat packet (tdest = PORT_ID, data 0xA1, 0xA2, 0xA3) with `en` = 4'hF. Expect:
  - `out_tdest` = 2; beats appear in order, with tlast on 0xA3.
  - `pkt_count` = 1.
  - First beat one cycle after `req`.
- **Round-robin:** all four ports continuously offer 2-beat packets. Expect grant order 0,1,2,3,0, with exactly 1 idle cycle between packets.
- **Filtering:**
  - Port 1 with tdest ≠ PORT_ID: expect `in_tready[1]` to stay 0 and no output.
  - `en[3]` = 0 with a valid request on port 3: expect the request to be ignored.
- **Backpressure and mid-packet events:** port 0 sends a packet; `out_tready` toggles 1,0,0,1; `en[0]` is cleared after the 1st beat. Expect no beat loss or duplication, and the packet completes. `pkt_count` saturates: preload to 0xFFFF via forced traffic and expect it to stay at 0xFFFF.
- **Reset mid-packet:** assert reset after beat 2 of a 4-beat packet. Expect outputs 0 immediately, and the next grant to go to port 0.
